// File: rtl/sync_down_timer.sv
// Loadable down-count timer: accepts a start value over valid/ready, decrements on
// enabled ticks, pulses tc for one cycle at terminal count, and can auto-reload.
module sync_down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick_en,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] Zero = '0;
  localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             w_reload_ok;

  // A zero reload value cannot restart the timer; it would only re-enter DONE.
  assign w_reload_ok = auto_reload && (r_reload != Zero);

  // State, count and reload register; the single FSM for the timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StIdle;
      r_count  <= Zero;
      r_reload <= Zero;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (load_valid) begin
            r_count  <= load_value;
            r_reload <= load_value;
            r_state  <= (load_value != Zero) ? StRun : StDone;
          end
        end
        StRun: begin
          if (abort) begin
            r_count <= Zero;
            r_state <= StIdle;
          end else if (tick_en) begin
            if (r_count > One) begin
              r_count <= r_count - One;
            end else begin
              // Reaching zero enters DONE on the same edge, so tc lines up with count==0.
              // A stray zero count also lands here instead of wrapping.
              r_count <= Zero;
              r_state <= StDone;
            end
          end
        end
        StDone: begin
          if (abort) begin
            r_count <= Zero;
            r_state <= StIdle;
          end else if (w_reload_ok) begin
            r_count <= r_reload;
            r_state <= StRun;
          end else begin
            r_count <= Zero;
            r_state <= StIdle;
          end
        end
        default: begin
          r_count <= Zero;
          r_state <= StIdle;
        end
      endcase
    end
  end

  // Handshake and status flags are decoded purely from the state register.
  always_comb begin
    load_ready = (r_state == StIdle);
    busy       = (r_state != StIdle);
    tc         = (r_state == StDone);
  end

  assign count = r_count;

endmodule
